// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants for the regfile writeback arbiter
package regfile_wb_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// rtl/regfile_wb_arbiter_rr_arbiter2.sv - two-request round-robin arbiter
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic ptr;

  always_comb begin
    gnt    = '0;
    gnt_id = SRC_ALU;
    if (req[0] && req[1]) begin
      gnt_id = ptr;
    end else if (req[1]) begin
      gnt_id = SRC_MEM;
    end
    gnt[gnt_id] = |req;
  end

  // Loser of this round becomes the preferred source next round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= SRC_ALU;
    end else if (|req) begin
      ptr <= ~gnt_id;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the regfile write port between ALU and load
// writeback, and tracks pending writes for RAW stalls.
module regfile_wb_arbiter #(
  parameter int XLEN = regfile_wb_arbiter_pkg::XLEN,
  parameter int AW   = regfile_wb_arbiter_pkg::AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [AW-1:0]     alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [AW-1:0]     mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  output logic              mem_ready,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rf_wen,
  output logic [AW-1:0]     rf_rd,
  output logic [XLEN-1:0]   rf_din,
  output logic [2**AW-1:0]  busy_vec
);
  import regfile_wb_arbiter_pkg::*;

  localparam int NREG = 2**AW;

  logic [1:0]      gnt;
  logic            gnt_id;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;
  logic            win_wr;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] busy_next;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({mem_valid, alu_valid}),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign alu_ready = gnt[SRC_ALU];
  assign mem_ready = gnt[SRC_MEM];

  assign win_rd   = (gnt_id == SRC_MEM) ? mem_rd   : alu_rd;
  assign win_data = (gnt_id == SRC_MEM) ? mem_data : alu_data;
  // Writes to x0 are accepted but never reach the regfile or scoreboard.
  assign win_wr   = (|gnt) && (win_rd != AW'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen <= 1'b0;
      rf_rd  <= '0;
      rf_din <= '0;
    end else begin
      rf_wen <= win_wr;
      if (win_wr) begin
        rf_rd  <= win_rd;
        rf_din <= win_data;
      end
    end
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_valid && (iss_rd != AW'(REG_ZERO))) begin
      set_vec[iss_rd] = 1'b1;
    end
    if (win_wr) begin
      clr_vec[win_rd] = 1'b1;
    end
    // Set after clear so a same-edge issue keeps the register pending.
    busy_next = (busy_vec & ~clr_vec) | set_vec;
    busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

  assign rs1_busy = busy_vec[rs1];
  assign rs2_busy = busy_vec[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst_n;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            mem_valid;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rf_wen;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_din;
  logic [31:0]     busy_vec;

  int n_checks;
  int n_fail;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .rf_wen    (rf_wen),
    .rf_rd     (rf_rd),
    .rf_din    (rf_din),
    .busy_vec  (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
  endtask

  logic [AW-1:0] exp_rd  [4];
  logic          exp_gnt [4];
  int            alu_i;
  int            mem_i;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rs1      = '0;
    rs2      = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_wen", rf_wen, 0);
    check("reset_rf_rd", rf_rd, 0);
    check("reset_rf_din", rf_din, 0);
    check("reset_busy_vec", busy_vec, 0);
    rst_n = 1'b1;

    // Reset asserted while a write is on the port and a register is pending.
    iss_valid = 1'b1; iss_rd = 5'd6;
    step();
    iss_valid = 1'b0;
    check("pre_reset_busy", busy_vec, 32'h0000_0040);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hA5A5_A5A5;
    #1;
    check("pre_reset_alu_ready", alu_ready, 1);
    step();
    check("pre_reset_rf_wen", rf_wen, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_rf_wen", rf_wen, 0);
    check("async_reset_busy_vec", busy_vec, 0);
    check("async_reset_rf_din", rf_din, 0);
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Both sources contending from reset: ALU preferred first, then alternate.
    exp_gnt = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_rd  = '{5'd1, 5'd9, 5'd2, 5'd10};
    alu_i = 1;
    mem_i = 9;
    for (int c = 0; c < 4; c++) begin
      alu_valid = 1'b1; alu_rd = AW'(alu_i); alu_data = 32'h100 + 32'(alu_i);
      mem_valid = 1'b1; mem_rd = AW'(mem_i); mem_data = 32'h200 + 32'(mem_i);
      #1;
      check($sformatf("rr_alu_ready_%0d", c), alu_ready, !exp_gnt[c]);
      check($sformatf("rr_mem_ready_%0d", c), mem_ready, exp_gnt[c]);
      step();
      check($sformatf("rr_rf_wen_%0d", c), rf_wen, 1);
      check($sformatf("rr_rf_rd_%0d", c), rf_rd, exp_rd[c]);
      check($sformatf("rr_rf_din_%0d", c), rf_din,
            exp_gnt[c] ? 32'h200 + 32'(exp_rd[c]) : 32'h100 + 32'(exp_rd[c]));
      if (exp_gnt[c]) mem_i++;
      else alu_i++;
    end
    idle_inputs();
    #1;
    check("idle_alu_ready", alu_ready, 0);
    check("idle_mem_ready", mem_ready, 0);
    step();
    check("idle_rf_wen", rf_wen, 0);

    // Single source on the load path.
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234_5678;
    #1;
    check("single_mem_ready", mem_ready, 1);
    check("single_alu_ready", alu_ready, 0);
    step();
    idle_inputs();
    check("single_rf_wen", rf_wen, 1);
    check("single_rf_rd", rf_rd, 7);
    check("single_rf_din", rf_din, 32'h1234_5678);
    step();
    check("single_rf_wen_drop", rf_wen, 0);
    step();

    // ptr held across idle cycles: ALU preferred after the MEM grant.
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h0000_0020;
    mem_valid = 1'b1; mem_rd = 5'd21; mem_data = 32'h0000_0021;
    #1;
    check("ptr_hold_alu_ready", alu_ready, 1);
    check("ptr_hold_mem_ready", mem_ready, 0);
    step();
    idle_inputs();
    check("ptr_hold_rf_rd", rf_rd, 20);

    // Writes to x0: accepted, no regfile write, scoreboard untouched.
    iss_valid = 1'b1; iss_rd = 5'd8;
    step();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    check("x0_alu_ready", alu_ready, 1);
    step();
    idle_inputs();
    check("x0_rf_wen", rf_wen, 0);
    check("x0_busy_vec", busy_vec, 32'h0000_0100);

    // Scoreboard set, clear, and same-edge set-wins.
    iss_valid = 1'b1; iss_rd = 5'd3;
    step();
    iss_valid = 1'b0;
    rs1 = 5'd3; rs2 = 5'd0;
    #1;
    check("sb_rs1_busy", rs1_busy, 1);
    check("sb_rs2_x0_busy", rs2_busy, 0);
    check("sb_busy_vec", busy_vec, 32'h0000_0108);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hCAFE_0003;
    step();
    idle_inputs();
    check("sb_clr_rf_wen", rf_wen, 1);
    check("sb_clr_busy_vec", busy_vec, 32'h0000_0100);
    check("sb_clr_rs1_busy", rs1_busy, 0);
    iss_valid = 1'b1; iss_rd = 5'd3;
    step();
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hBEEF_0003;
    iss_valid = 1'b1; iss_rd = 5'd3;
    rs2 = 5'd8;
    #1;
    check("sb_rs2_busy", rs2_busy, 1);
    step();
    idle_inputs();
    check("sb_same_edge_rf_wen", rf_wen, 1);
    check("sb_same_edge_rf_rd", rf_rd, 3);
    check("sb_same_edge_busy_vec", busy_vec, 32'h0000_0108);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
